// File: rtl/cpu_queue_pkg.sv
// Shared definitions for the core issue queue: instruction field positions,
// scoreboard key width and the issue FSM state encoding.
package cpu_queue_pkg;

  localparam int INSTR_W       = 32;
  localparam int KEY_W         = 12;
  localparam int PIN_BIT       = 27;
  localparam int CORE_BIT      = 26;
  localparam int SRC_FLAG_BIT  = 23;
  localparam int DEST_FLAG_BIT = 22;
  localparam int DEST_MSB      = 21;
  localparam int DEST_LSB      = 11;
  localparam int SRC_MSB       = 10;
  localparam int SRC_LSB       = 0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ISSUE = 2'd1,
    ST_STALL = 2'd2
  } iq_state_e;

endpackage

// File: rtl/dest_scoreboard.sv
// Outstanding-destination scoreboard. Match and full outputs reflect the
// state after this cycle's allocate/clear so the next head sees fresh data.
module dest_scoreboard
  import cpu_queue_pkg::*;
#(
  parameter int OUT_MAX = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               alloc_en,
  input  logic [KEY_W-1:0]   alloc_key,
  input  logic               clr_en,
  input  logic [KEY_W-1:0]   clr_key,
  input  logic [KEY_W-1:0]   query_src,
  input  logic [KEY_W-1:0]   query_dest,
  output logic [OUT_MAX-1:0] match_vec,
  output logic               full
);

  logic [OUT_MAX-1:0] valid_q;
  logic [OUT_MAX-1:0] valid_d;
  logic [KEY_W-1:0]   key_q [OUT_MAX];
  logic [KEY_W-1:0]   key_d [OUT_MAX];
  logic               clr_done;
  logic               alloc_done;

  // Clear lowest matching valid entry, allocate lowest free entry (both on pre-update state).
  always_comb begin
    valid_d    = valid_q;
    key_d      = key_q;
    clr_done   = 1'b0;
    alloc_done = 1'b0;
    for (int i = 0; i < OUT_MAX; i++) begin
      if (clr_en && !clr_done && valid_q[i] && (key_q[i] == clr_key)) begin
        valid_d[i] = 1'b0;
        clr_done   = 1'b1;
      end else if (alloc_en && !alloc_done && !valid_q[i]) begin
        valid_d[i] = 1'b1;
        key_d[i]   = alloc_key;
        alloc_done = 1'b1;
      end else begin
        valid_d[i] = valid_d[i];
      end
    end
  end

  // Post-update hazard view for the query keys.
  always_comb begin
    for (int i = 0; i < OUT_MAX; i++) begin
      match_vec[i] = valid_d[i] && ((key_d[i] == query_src) || (key_d[i] == query_dest));
    end
    full = &valid_d;
  end

  // Scoreboard state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      key_q   <= '{default: '0};
    end else begin
      valid_q <= valid_d;
      key_q   <= key_d;
    end
  end

endmodule

// File: rtl/core_issue_queue.sv
// In-order issue queue: FIFO of instructions whose head is offered to the
// core only when no outstanding destination conflicts with it.
module core_issue_queue
  import cpu_queue_pkg::*;
#(
  parameter int DEPTH   = 32,
  parameter int OUT_MAX = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_valid,
  input  logic [INSTR_W-1:0]       push_instr,
  output logic                     push_ready,
  output logic                     issue_valid,
  output logic [INSTR_W-1:0]       issue_instr,
  input  logic                     issue_ready,
  input  logic                     wb_valid,
  input  logic [KEY_W-1:0]         wb_key,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     hazard_stall
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [INSTR_W-1:0] head_q, head_d;
  iq_state_e          state_q, state_d;
  logic               do_push;
  logic               do_pop;
  logic [OUT_MAX-1:0] match_vec;
  logic               sb_full;
  logic [KEY_W-1:0]   head_src_key;
  logic [KEY_W-1:0]   head_dest_key;
  logic [KEY_W-1:0]   issue_dest_key;

  assign push_ready   = !reset && (count_q < DEPTH_C);
  assign issue_valid  = (state_q == ST_ISSUE);
  assign hazard_stall = (state_q == ST_STALL);
  assign issue_instr  = head_q;
  assign count        = count_q;

  assign head_src_key   = {head_d[SRC_FLAG_BIT], head_d[SRC_MSB:SRC_LSB]};
  assign head_dest_key  = {head_d[DEST_FLAG_BIT], head_d[DEST_MSB:DEST_LSB]};
  assign issue_dest_key = {head_q[DEST_FLAG_BIT], head_q[DEST_MSB:DEST_LSB]};

  // Pointer/occupancy update, next head selection and FSM next state.
  always_comb begin
    do_push  = push_valid && push_ready && !flush;
    do_pop   = issue_valid && issue_ready && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = '0;
    state_d  = ST_EMPTY;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    // A push landing in the slot that becomes head must be forwarded into the head register.
    if (count_d == '0) begin
      head_d = '0;
    end else if (do_push && (wr_ptr_q == rd_ptr_d)) begin
      head_d = push_instr;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end

    if (count_d == '0) begin
      state_d = ST_EMPTY;
    end else if ((|match_vec) || sb_full) begin
      state_d = ST_STALL;
    end else begin
      state_d = ST_ISSUE;
    end
  end

  // Instruction storage; contents are don't-care until pointed to.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_instr;
    end
  end

  // Control and head registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      state_q  <= ST_EMPTY;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      state_q  <= state_d;
    end
  end

  dest_scoreboard #(
    .OUT_MAX (OUT_MAX)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .alloc_en   (do_pop),
    .alloc_key  (issue_dest_key),
    .clr_en     (wb_valid),
    .clr_key    (wb_key),
    .query_src  (head_src_key),
    .query_dest (head_dest_key),
    .match_vec  (match_vec),
    .full       (sb_full)
  );

endmodule

// File: tb/tb_core_issue_queue.sv
// Randomized and directed bench for core_issue_queue against a queue-based
// reference model of FIFO order, scoreboard hazards and flush/reset.
module tb_core_issue_queue;

  localparam int DEPTH   = 32;
  localparam int OUT_MAX = 4;
  localparam int CW      = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          push_valid;
  logic [31:0]   push_instr;
  logic          push_ready;
  logic          issue_valid;
  logic [31:0]   issue_instr;
  logic          issue_ready;
  logic          wb_valid;
  logic [11:0]   wb_key;
  logic          flush;
  logic [CW-1:0] count;
  logic          hazard_stall;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] mq[$];
  logic [11:0] msb[$];
  logic        m_valid;
  logic        m_stall;
  logic [31:0] m_instr;

  always #5 clk = ~clk;

  core_issue_queue #(.DEPTH(DEPTH), .OUT_MAX(OUT_MAX)) dut (
    .clk          (clk),
    .reset        (reset),
    .push_valid   (push_valid),
    .push_instr   (push_instr),
    .push_ready   (push_ready),
    .issue_valid  (issue_valid),
    .issue_instr  (issue_instr),
    .issue_ready  (issue_ready),
    .wb_valid     (wb_valid),
    .wb_key       (wb_key),
    .flush        (flush),
    .count        (count),
    .hazard_stall (hazard_stall)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [11:0] skey(input logic [31:0] i);
    return {i[23], i[10:0]};
  endfunction

  function automatic logic [11:0] dkey(input logic [31:0] i);
    return {i[22], i[21:11]};
  endfunction

  function automatic logic [31:0] mk(input logic [7:0] tag, input logic [11:0] sk, input logic [11:0] dk);
    return {tag, sk[11], dk[11], dk[10:0], sk[10:0]};
  endfunction

  // Recompute what the queue should offer from the model's queue and scoreboard.
  task automatic model_head();
    logic blk;
    if (mq.size() == 0) begin
      m_valid = 1'b0; m_stall = 1'b0; m_instr = 32'h0;
    end else begin
      blk = (msb.size() >= OUT_MAX);
      foreach (msb[k]) if (msb[k] == skey(mq[0]) || msb[k] == dkey(mq[0])) blk = 1'b1;
      m_valid = !blk; m_stall = blk; m_instr = mq[0];
    end
  endtask

  task automatic step(input logic pv, input logic [31:0] pi, input logic ir,
                      input logic wv, input logic [11:0] wk, input logic fl);
    logic pop, push, found;
    push_valid = pv; push_instr = pi; issue_ready = ir;
    wb_valid = wv; wb_key = wk; flush = fl;
    pop  = m_valid && ir && !fl;
    push = pv && (mq.size() < DEPTH) && !fl;
    found = 1'b0;
    if (wv) begin
      for (int k = 0; k < msb.size(); k++) begin
        if (!found && msb[k] == wk) begin
          msb.delete(k);
          found = 1'b1;
        end
      end
    end
    if (fl) mq.delete();
    else begin
      if (pop) begin
        msb.push_back(dkey(mq[0]));
        void'(mq.pop_front());
      end
      if (push) mq.push_back(pi);
    end
    model_head();
    @(posedge clk); #1;
    check_eq("count", 32'(count), mq.size());
    check_eq("push_ready", 32'(push_ready), 32'(mq.size() < DEPTH));
    check_eq("issue_valid", 32'(issue_valid), 32'(m_valid));
    check_eq("hazard_stall", 32'(hazard_stall), 32'(m_stall));
    check_eq("issue_instr", issue_instr, m_instr);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; push_valid = 1'b1; push_instr = 32'hdead_beef;
    issue_ready = 1'b1; wb_valid = 1'b1; wb_key = 12'h000; flush = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_issue_valid", 32'(issue_valid), 32'd0);
    check_eq("rst_issue_instr", issue_instr, 32'd0);
    check_eq("rst_hazard", 32'(hazard_stall), 32'd0);
    check_eq("rst_push_ready", 32'(push_ready), 32'd0);
    mq.delete(); msb.delete();
    model_head();
    reset = 1'b0; push_valid = 1'b0; flush = 1'b0; wb_valid = 1'b0; issue_ready = 1'b0;
    #1;
    check_eq("post_rst_push_ready", 32'(push_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int budget;
    logic [11:0] sk, dk, wk;
    logic [31:0] pi;
    reset = 1'b1; push_valid = 1'b0; push_instr = 32'h0; issue_ready = 1'b0;
    wb_valid = 1'b0; wb_key = 12'h0; flush = 1'b0;
    do_reset(3);

    // Single instruction, no bypass, count 1 -> 0.
    step(1'b1, 32'h0000_0801, 1'b1, 1'b0, 12'h0, 1'b0);
    check_eq("r032_valid", 32'(issue_valid), 32'd1);
    check_eq("r032_instr", issue_instr, 32'h0000_0801);
    step(1'b0, 32'h0, 1'b1, 1'b0, 12'h0, 1'b0);
    check_eq("r032_count0", 32'(count), 32'd0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 12'h001, 1'b0);

    // Fill to capacity, drop the 33rd, then drain in order.
    for (int i = 0; i < 33; i++) begin
      step(1'b1, {8'(i), 24'h0}, 1'b0, 1'b0, 12'h0, 1'b0);
      if (i == 31) check_eq("r033_ready_low", 32'(push_ready), 32'd0);
    end
    check_eq("r033_count32", 32'(count), 32'd32);
    idx = 0; budget = 0;
    while (idx < 32 && budget < 200) begin
      if (issue_valid) begin
        check_eq("r033_order", issue_instr, {8'(idx), 24'h0});
        idx++;
      end
      step(1'b0, 32'h0, 1'b1, 1'b1, 12'h000, 1'b0);
      budget++;
    end
    check_eq("r033_drained", idx, 32'd32);
    step(1'b0, 32'h0, 1'b0, 1'b1, 12'h000, 1'b0);

    // RAW hazard on dest 0x005 and wb unblock next cycle.
    step(1'b1, mk(8'h01, 12'h0aa, 12'h005), 1'b0, 1'b0, 12'h0, 1'b0);
    step(1'b1, mk(8'h02, 12'h005, 12'h0bb), 1'b1, 1'b0, 12'h0, 1'b0);
    check_eq("r034_stall", 32'(hazard_stall), 32'd1);
    step(1'b0, 32'h0, 1'b1, 1'b1, 12'h005, 1'b0);
    check_eq("r034_unblock", 32'(issue_valid), 32'd1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 12'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 12'h0bb, 1'b0);

    // Scoreboard full after four outstanding writes.
    for (int i = 0; i < 5; i++)
      step(1'b1, mk(8'(i), 12'(12'h100 + i), 12'(12'h010 + i)), 1'b0, 1'b0, 12'h0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 12'h0, 1'b0);
    check_eq("r035_full_stall", 32'(hazard_stall), 32'd1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 12'h0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b1, 12'h011, 1'b0);
    check_eq("r035_unblock", 32'(issue_valid), 32'd1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 12'h0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b0, 1'b1, 12'(12'h010 + i), 1'b0);

    // Flush with 10 queued plus a push; scoreboard must survive.
    step(1'b1, mk(8'h0c, 12'h0c0, 12'h033), 1'b1, 1'b0, 12'h0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 12'h0, 1'b0);
    for (int i = 0; i < 10; i++)
      step(1'b1, mk(8'(i), 12'(12'h200 + i), 12'(12'h300 + i)), 1'b0, 1'b0, 12'h0, 1'b0);
    check_eq("r036_count10", 32'(count), 32'd10);
    step(1'b1, mk(8'hff, 12'h0, 12'h0), 1'b1, 1'b0, 12'h0, 1'b1);
    check_eq("r036_count0", 32'(count), 32'd0);
    check_eq("r036_valid0", 32'(issue_valid), 32'd0);
    step(1'b1, mk(8'h0d, 12'h033, 12'h044), 1'b0, 1'b0, 12'h0, 1'b0);
    check_eq("r036_sb_kept", 32'(hazard_stall), 32'd1);
    step(1'b0, 32'h0, 1'b1, 1'b1, 12'h033, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 12'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 12'h044, 1'b0);

    // Reset while stalled with seven queued.
    step(1'b1, mk(8'h0e, 12'h0e0, 12'h040), 1'b0, 1'b0, 12'h0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 12'h0, 1'b0);
    for (int i = 0; i < 7; i++)
      step(1'b1, mk(8'(i), 12'h040, 12'(12'h050 + i)), 1'b0, 1'b0, 12'h0, 1'b0);
    check_eq("r037_count7", 32'(count), 32'd7);
    check_eq("r037_stalled", 32'(hazard_stall), 32'd1);
    do_reset(1);

    // Random traffic over a small key pool to provoke hazards.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset(1);
      end else begin
        sk = {1'($urandom), 8'h0, 3'($urandom)};
        dk = {1'($urandom), 8'h0, 3'($urandom)};
        pi = mk(8'($urandom), sk, dk);
        if (msb.size() > 0 && $urandom_range(0, 3) != 0) wk = msb[$urandom_range(0, msb.size() - 1)];
        else wk = {1'($urandom), 8'h0, 3'($urandom)};
        step(1'($urandom_range(0, 9) < 6), pi, 1'($urandom_range(0, 9) < 7),
             1'($urandom_range(0, 1)), wk, 1'($urandom_range(0, 59) == 0));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
